// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
`default_nettype none

package fetch_pkg;
  localparam int          INST_W  = 32;
  localparam logic [31:0] I_NOP   = 32'h0000_0013;
  localparam int          PC_STEP = 4;

  function automatic int fq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, inst} entries; head is read straight from the storage flops.
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int W     = 64,
  parameter  int DEPTH = 2,
  localparam int PTR_W = fq_ptr_w(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic           i_clear,
  input  logic [W-1:0]   i_wdata,
  output logic [W-1:0]   o_head,
  output logic [PTR_W:0] o_count,
  output logic           o_valid
);
  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W:0]   r_count;

  // Caller guarantees no push when full without a pop, and no pop when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PTR_W'(1);
      if (i_pop)  r_rd <= r_rd + PTR_W'(1);
      r_count <= r_count + {{PTR_W{1'b0}}, i_push} - {{PTR_W{1'b0}}, i_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_valid = (r_count != '0);
endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// PC register plus decoupled fetch queue feeding decode over valid/ready.
// Optional FETCH_PERF_EN adds fetch/kill performance counters.
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int              XLEN     = 32,
  parameter  logic [XLEN-1:0] RESET_PC = '0,
  parameter  int              FQ_DEPTH = 2,
  localparam int              CNT_W    = fq_ptr_w(FQ_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [XLEN-1:0]   imem_addr,
  output logic              imem_req,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [XLEN-1:0]   id_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_kill_cnt,
`endif
  output logic [CNT_W-1:0]  fq_count
);
  localparam int ENT_W = XLEN + INST_W;

  logic [XLEN-1:0]  r_pc;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_q_valid;
  logic [ENT_W-1:0] w_head;
  logic [XLEN-1:0]  w_redir_tgt;

  assign w_full      = (fq_count == CNT_W'(FQ_DEPTH));
  assign w_pop       = w_q_valid & id_ready;
  assign w_push      = ~redirect_valid & (~w_full | w_pop);
  assign w_redir_tgt = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redir_tgt;
    end else if (w_push) begin
      r_pc <= r_pc + XLEN'(PC_STEP);
    end
  end

  // Redirect clears the queue, so a simultaneous pop is simply dropped.
  fetch_queue #(
    .W     (ENT_W),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop & ~redirect_valid),
    .i_clear (redirect_valid),
    .i_wdata ({r_pc, imem_data}),
    .o_head  (w_head),
    .o_count (fq_count),
    .o_valid (w_q_valid)
  );

  assign imem_addr = r_pc;
  assign imem_req  = w_push;
  assign id_valid  = w_q_valid;
  assign id_inst   = w_q_valid ? w_head[INST_W-1:0]     : I_NOP;
  assign id_pc     = w_q_valid ? w_head[ENT_W-1:INST_W] : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_kill_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_kill_cnt  <= '0;
    end else begin
      if (w_push)         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (redirect_valid) r_kill_cnt  <= r_kill_cnt + 32'(fq_count);
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_kill_cnt  = r_kill_cnt;
`endif
endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed literal checks.
`default_nettype none

module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [1:0]  fq_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'hA000_0000 | imem_addr;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_kill_cnt  (perf_kill_cnt),
`endif
    .fq_count       (fq_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, inst} and a fetch pointer.
  logic [63:0] q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_kill;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_pc    = 32'h0;
      m_fetch = 0;
      m_kill  = 0;
    end else begin
      int  sz;
      bit  pop, push;
      sz   = q.size();
      pop  = (sz > 0) && id_ready;
      push = !redirect_valid && ((sz < DEPTH) || pop);
      if (redirect_valid) begin
        m_kill += 32'(sz);
        q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back({m_pc, 32'hA000_0000 | m_pc});
          m_pc    = m_pc + 32'd4;
          m_fetch = m_fetch + 1;
        end
      end
    end
  end

  // Compare every cycle, well after the edge and before inputs change at negedge.
  always begin
    @(posedge clk);
    #3;
    if (!rst) begin
      bit ev;
      ev = q.size() > 0;
      chk("m_valid", 32'(id_valid), 32'(ev));
      chk("m_pc",    id_pc,   ev ? q[0][63:32] : 32'h0);
      chk("m_inst",  id_inst, ev ? q[0][31:0]  : 32'h13);
      chk("m_count", 32'(fq_count), 32'(q.size()));
      chk("m_addr",  imem_addr, m_pc);
      chk("m_req",   32'(imem_req),
          32'(!redirect_valid && ((q.size() < DEPTH) || (ev && id_ready))));
`ifdef FETCH_PERF_EN
      chk("m_pfetch", perf_fetch_cnt, m_fetch);
      chk("m_pkill",  perf_kill_cnt,  m_kill);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst",  id_inst, 32'h13);
    chk("rst_pc",    id_pc, 32'h0);
    chk("rst_count", 32'(fq_count), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);

    // Streaming with decode always ready
    rst = 1'b0;
    id_ready = 1'b1;
    cyc();
    chk("s_pc0",   id_pc, 32'h0);
    chk("s_inst0", id_inst, 32'hA000_0000);
    cyc();
    chk("s_pc1",   id_pc, 32'h4);
    chk("s_inst1", id_inst, 32'hA000_0004);
    cyc();
    chk("s_pc2",   id_pc, 32'h8);

    // Backpressure fills the queue and stalls the PC
    do_reset();
    cyc();
    cyc();
    chk("bp_count", 32'(fq_count), 32'd2);
    chk("bp_req",   32'(imem_req), 32'd0);
    chk("bp_addr",  imem_addr, 32'h8);
    cyc();
    chk("bp_hold",  imem_addr, 32'h8);
    chk("bp_head",  id_pc, 32'h0);
    @(negedge clk);
    id_ready = 1'b1;
    // Full queue with continuous pop: one in, one out per cycle
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("full_pc",    id_pc, 32'(4 * (k + 1)));
      chk("full_count", 32'(fq_count), 32'd2);
    end

    // Redirect kills a full queue
    begin
      logic [31:0] k0;
`ifdef FETCH_PERF_EN
      k0 = perf_kill_cnt;
`else
      k0 = 0;
`endif
      @(negedge clk);
      id_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h103;
      cyc();
      chk("rd_count", 32'(fq_count), 32'd0);
      chk("rd_valid", 32'(id_valid), 32'd0);
      chk("rd_addr",  imem_addr, 32'h100);
`ifdef FETCH_PERF_EN
      chk("rd_kill",  perf_kill_cnt, k0 + 32'd2);
`else
      k0 = k0 + 1;
`endif
      @(negedge clk);
      redirect_valid = 1'b0;
      cyc();
      chk("rd_pc",    id_pc, 32'h100);
      chk("rd_inst",  id_inst, 32'hA000_0100);
    end

    // PC wrap
    @(negedge clk);
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    cyc();
    chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    redirect_valid = 1'b0;
    cyc();
    chk("wr_pc0",   id_pc, 32'hFFFF_FFFC);
    chk("wr_addr1", imem_addr, 32'h0);
    cyc();
    chk("wr_pc1",   id_pc, 32'h0);
    chk("wr_inst1", id_inst, 32'hA000_0000);

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(id_valid), 32'd0);
    chk("ar_addr",  imem_addr, 32'h0);
    chk("ar_count", 32'(fq_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 2))
        0:       redirect_pc = $urandom();
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: redirect_pc = 32'($urandom_range(0, 255));
      endcase
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
